// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with prioritised trap entry.
// Optional 64-bit retired-instruction counter enabled by defining INSTRET_COUNTER_EN.
module core_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        clk,
   input  logic        resetb,
   output logic        im_req,
   input  logic        im_ready,
   output logic        ir_we,
   input  logic [3:0]  dec_dm_be,
   input  logic        dec_dm_we,
   input  logic        dec_regwrite,
   input  logic        dec_csr_wr,
   input  logic        dec_redirect,
   input  logic        dec_mret,
   input  logic        dec_exc_unsupported,
   input  logic        dec_exc_illegal,
   input  logic        dec_exc_inst_misaligned,
   input  logic        dec_exc_mem_misaligned,
   output logic        dm_req,
   output logic        dm_we,
   input  logic        dm_ready,
   output logic        rf_we,
   output logic        csr_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        trap_enter,
   output logic [3:0]  trap_cause,
   output logic        instr_retired,
   output logic [63:0] instret,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEM       = 3'd4,
      S_WRITEBACK = 3'd5,
      S_TRAP      = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]       cause_q, cause_d;
   logic             timeout;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q <= S_RESET;
         cnt_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == TIMEOUT_VAL);

   // Counter defaults to zero outside the two wait states, which clears it on entry to either.
   always_comb begin
      state_d       = state_q;
      cnt_d         = '0;
      cause_d       = cause_q;
      im_req        = 1'b0;
      ir_we         = 1'b0;
      dm_req        = 1'b0;
      dm_we         = 1'b0;
      rf_we         = 1'b0;
      csr_we        = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = 2'd0;
      trap_enter    = 1'b0;
      trap_cause    = 4'd0;
      instr_retired = 1'b0;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            im_req = 1'b1;
            if (im_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               cause_d = 4'd1;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DECODE: begin
            if (dec_exc_inst_misaligned) begin
               cause_d = 4'd0;
               state_d = S_TRAP;
            end else if (dec_exc_illegal || dec_exc_unsupported) begin
               cause_d = 4'd2;
               state_d = S_TRAP;
            end else if (dec_exc_mem_misaligned) begin
               cause_d = dec_dm_we ? 4'd6 : 4'd4;
               state_d = S_TRAP;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: state_d = (dec_dm_be != '0) ? S_MEM : S_WRITEBACK;
         S_MEM: begin
            dm_req = 1'b1;
            dm_we  = dec_dm_we;
            if (dm_ready) begin
               state_d = S_WRITEBACK;
            end else if (timeout) begin
               cause_d = dec_dm_we ? 4'd7 : 4'd5;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WRITEBACK: begin
            rf_we         = dec_regwrite & ~dec_dm_we;
            csr_we        = dec_csr_wr;
            pc_we         = 1'b1;
            pc_sel        = dec_mret ? 2'd3 : (dec_redirect ? 2'd1 : 2'd0);
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_TRAP: begin
            trap_enter = 1'b1;
            trap_cause = cause_q;
            pc_we      = 1'b1;
            pc_sel     = 2'd2;
            state_d    = S_FETCH;
         end
         default: state_d = S_RESET;
      endcase
   end

   assign state = state_q;

`ifdef INSTRET_COUNTER_EN
   logic [63:0] instret_q;
   always_ff @(posedge clk) begin
      if (!resetb)            instret_q <= '0;
      else if (instr_retired) instret_q <= instret_q + 64'd1;
   end
   assign instret = instret_q;
`else
   assign instret = '0;
`endif

endmodule
